// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operation sequencer.
// Holds the opcode/funct constants of the supported instruction subset, the ALU
// function (af) encodings, the exception cause codes and the sequencer FSM states.
package alu_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OpRType = 6'h00;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpAddiu = 6'h09;
  localparam logic [5:0] OpSlti  = 6'h0A;
  localparam logic [5:0] OpSltiu = 6'h0B;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpXori  = 6'h0E;
  localparam logic [5:0] OpLui   = 6'h0F;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FnAdd  = 6'h20;
  localparam logic [5:0] FnAddu = 6'h21;
  localparam logic [5:0] FnSub  = 6'h22;
  localparam logic [5:0] FnSubu = 6'h23;
  localparam logic [5:0] FnAnd  = 6'h24;
  localparam logic [5:0] FnOr   = 6'h25;
  localparam logic [5:0] FnXor  = 6'h26;
  localparam logic [5:0] FnSlt  = 6'h2A;
  localparam logic [5:0] FnSltu = 6'h2B;

  // ALU function selector encodings
  localparam logic [3:0] AfAdd  = 4'b0000;
  localparam logic [3:0] AfAddu = 4'b0001;
  localparam logic [3:0] AfSub  = 4'b0010;
  localparam logic [3:0] AfSubu = 4'b0011;
  localparam logic [3:0] AfAnd  = 4'b0100;
  localparam logic [3:0] AfOr   = 4'b0101;
  localparam logic [3:0] AfXor  = 4'b0110;
  localparam logic [3:0] AfLui  = 4'b0111;
  localparam logic [3:0] AfSlt  = 4'b1010;
  localparam logic [3:0] AfSltu = 4'b1011;

  // Exception cause codes
  localparam logic [1:0] ExcNone     = 2'b00;
  localparam logic [1:0] ExcIllegal  = 2'b01;
  localparam logic [1:0] ExcOverflow = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StExec,
    StWb
  } state_e;

endpackage

// File: rtl/alu_decode.sv
// Combinational instruction decoder.
// Maps opcode/funct to the ALU selector, immediate select, zero-extend select and
// an illegal flag for anything outside the supported subset.
// Ports:
//   opcode, funct : instruction fields instr[31:26], instr[5:0]
//   af            : ALU function selector
//   imm_sel       : 1 selects the 16-bit immediate as second operand
//   zero_ext      : 1 zero-extends the immediate, 0 sign-extends
//   illegal       : unsupported opcode or funct
module alu_decode
  import alu_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] af,
  output logic       imm_sel,
  output logic       zero_ext,
  output logic       illegal
);

  always_comb begin
    af       = AfAdd;
    imm_sel  = 1'b0;
    zero_ext = 1'b0;
    illegal  = 1'b0;
    unique case (opcode)
      OpRType: begin
        unique case (funct)
          FnAdd:   af = AfAdd;
          FnAddu:  af = AfAddu;
          FnSub:   af = AfSub;
          FnSubu:  af = AfSubu;
          FnAnd:   af = AfAnd;
          FnOr:    af = AfOr;
          FnXor:   af = AfXor;
          FnSlt:   af = AfSlt;
          FnSltu:  af = AfSltu;
          default: illegal = 1'b1;
        endcase
      end
      OpAddi:  begin af = AfAdd;  imm_sel = 1'b1; end
      OpAddiu: begin af = AfAddu; imm_sel = 1'b1; end
      OpSlti:  begin af = AfSlt;  imm_sel = 1'b1; end
      OpSltiu: begin af = AfSltu; imm_sel = 1'b1; end
      OpAndi:  begin af = AfAnd;  imm_sel = 1'b1; zero_ext = 1'b1; end
      OpOri:   begin af = AfOr;   imm_sel = 1'b1; zero_ext = 1'b1; end
      OpXori:  begin af = AfXor;  imm_sel = 1'b1; zero_ext = 1'b1; end
      OpLui:   begin af = AfLui;  imm_sel = 1'b1; end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle sequencer driving an external ALU and register file.
// Flow: IDLE (accept) -> READ (operands, decode) -> EXEC (ALU) -> WB -> IDLE.
// Illegal instructions skip EXEC. Build option: define ALU_OVF_TRAP_EN to turn
// signed overflow on add/sub into an exception (cause 10) with writeback suppressed.
// Ports:
//   clk, rst_n                   : clock, asynchronous active-low reset
//   instr_valid/instr/instr_ready: instruction handshake (ready only in IDLE)
//   rf_raddr_a/b, rf_rdata_a/b   : register-file read (data one cycle after address)
//   alu_af/i/u/imm/srca/srcb     : ALU controls and operands, held during EXEC
//   alu_res/zero/neg/ovf         : ALU result and flags
//   wb_en/wb_addr/wb_data        : register writeback
//   done, exc, exc_cause         : completion and exception report
//   flag_z, flag_n               : registered result flags
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_valid,
  input  logic [31:0]   instr,
  output logic          instr_ready,
  output logic [AW-1:0] rf_raddr_a,
  output logic [AW-1:0] rf_raddr_b,
  input  logic [DW-1:0] rf_rdata_a,
  input  logic [DW-1:0] rf_rdata_b,
  output logic [3:0]    alu_af,
  output logic          alu_i,
  output logic          alu_u,
  output logic [15:0]   alu_imm,
  output logic [DW-1:0] alu_srca,
  output logic [DW-1:0] alu_srcb,
  input  logic [DW-1:0] alu_res,
  input  logic          alu_zero,
  input  logic          alu_neg,
  input  logic          alu_ovf,
  output logic          wb_en,
  output logic [AW-1:0] wb_addr,
  output logic [DW-1:0] wb_data,
  output logic          done,
  output logic          exc,
  output logic [1:0]    exc_cause,
  output logic          flag_z,
  output logic          flag_n
);

  state_e        state_q, state_d;
  logic [31:0]   instr_q;
  logic [DW-1:0] srca_q, srcb_q, res_q;
  logic [3:0]    af_q;
  logic          i_q, u_q, illegal_q;
  logic          zero_q, neg_q, ovf_q;
  logic          flag_z_q, flag_n_q;
  logic [1:0]    exc_cause_q;

  logic [3:0]    dec_af;
  logic          dec_i, dec_u, dec_illegal;
  logic          ovf_trap;
  logic [1:0]    cause;
  logic          in_wb;
  logic [31:0]   raddr_src;

  alu_decode u_decode (
    .opcode   (instr_q[31:26]),
    .funct    (instr_q[5:0]),
    .af       (dec_af),
    .imm_sel  (dec_i),
    .zero_ext (dec_u),
    .illegal  (dec_illegal)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (instr_valid) state_d = StRead;
      StRead:  state_d = dec_illegal ? StWb : StExec;
      StExec:  state_d = StWb;
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

`ifdef ALU_OVF_TRAP_EN
  assign ovf_trap = ovf_q && ((af_q == AfAdd) || (af_q == AfSub));
`else
  logic unused_ovf;
  assign unused_ovf = ovf_q;
  assign ovf_trap   = 1'b0;
`endif

  // Illegal wins: ovf_q is stale when EXEC was skipped.
  always_comb begin
    cause = ExcNone;
    if (illegal_q)     cause = ExcIllegal;
    else if (ovf_trap) cause = ExcOverflow;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      instr_q     <= '0;
      srca_q      <= '0;
      srcb_q      <= '0;
      af_q        <= '0;
      i_q         <= 1'b0;
      u_q         <= 1'b0;
      illegal_q   <= 1'b0;
      res_q       <= '0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      ovf_q       <= 1'b0;
      flag_z_q    <= 1'b0;
      flag_n_q    <= 1'b0;
      exc_cause_q <= ExcNone;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && instr_valid) instr_q <= instr;
      if (state_q == StRead) begin
        srca_q    <= rf_rdata_a;
        srcb_q    <= rf_rdata_b;
        af_q      <= dec_af;
        i_q       <= dec_i;
        u_q       <= dec_u;
        illegal_q <= dec_illegal;
      end
      if (state_q == StExec) begin
        res_q  <= alu_res;
        zero_q <= alu_zero;
        neg_q  <= alu_neg;
        ovf_q  <= alu_ovf;
      end
      if (state_q == StWb) begin
        exc_cause_q <= cause;
        if (cause == ExcNone) begin
          flag_z_q <= zero_q;
          flag_n_q <= neg_q;
        end
      end
    end
  end

  // In IDLE the address comes straight from the offered word so the register file
  // sees it at the accept edge and returns data during READ.
  assign raddr_src   = (state_q == StIdle) ? instr : instr_q;
  assign rf_raddr_a  = AW'(raddr_src[25:21]);
  assign rf_raddr_b  = AW'(raddr_src[20:16]);

  assign instr_ready = (state_q == StIdle);
  assign in_wb       = (state_q == StWb);

  assign alu_af   = af_q;
  assign alu_i    = i_q;
  assign alu_u    = u_q;
  assign alu_imm  = instr_q[15:0];
  assign alu_srca = srca_q;
  assign alu_srcb = srcb_q;

  assign wb_addr   = i_q ? AW'(instr_q[20:16]) : AW'(instr_q[15:11]);
  assign wb_data   = res_q;
  assign wb_en     = in_wb && (cause == ExcNone) && (wb_addr != '0);
  assign done      = in_wb;
  assign exc       = in_wb && (cause != ExcNone);
  assign exc_cause = in_wb ? cause : exc_cause_q;
  assign flag_z    = flag_z_q;
  assign flag_n    = flag_n_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          instr_valid;
  logic [31:0]   instr;
  logic          instr_ready;
  logic [AW-1:0] rf_raddr_a, rf_raddr_b;
  logic [DW-1:0] rf_rdata_a, rf_rdata_b;
  logic [3:0]    alu_af;
  logic          alu_i, alu_u;
  logic [15:0]   alu_imm;
  logic [DW-1:0] alu_srca, alu_srcb, alu_res;
  logic          alu_zero, alu_neg, alu_ovf;
  logic          wb_en;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          done, exc;
  logic [1:0]    exc_cause;
  logic          flag_z, flag_n;

  alu_op_sequencer #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
    .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
    .alu_af(alu_af), .alu_i(alu_i), .alu_u(alu_u), .alu_imm(alu_imm),
    .alu_srca(alu_srca), .alu_srcb(alu_srcb),
    .alu_res(alu_res), .alu_zero(alu_zero), .alu_neg(alu_neg), .alu_ovf(alu_ovf),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .done(done), .exc(exc), .exc_cause(exc_cause),
    .flag_z(flag_z), .flag_n(flag_n)
  );

  always #5 clk = ~clk;

  // Register file: synchronous read, static contents set by each test.
  logic [31:0] rf [32];
  always @(posedge clk) begin
    rf_rdata_a <= rf[rf_raddr_a];
    rf_rdata_b <= rf[rf_raddr_b];
  end

  // External ALU
  logic [31:0] opb;
  always_comb begin
    opb      = alu_i ? (alu_u ? {16'h0, alu_imm} : {{16{alu_imm[15]}}, alu_imm}) : alu_srcb;
    alu_res  = '0;
    alu_ovf  = 1'b0;
    case (alu_af)
      4'b0000, 4'b0001: begin
        alu_res = alu_srca + opb;
        alu_ovf = (alu_srca[31] == opb[31]) && (alu_res[31] != alu_srca[31]);
      end
      4'b0010, 4'b0011: begin
        alu_res = alu_srca - opb;
        alu_ovf = (alu_srca[31] != opb[31]) && (alu_res[31] != alu_srca[31]);
      end
      4'b0100: alu_res = alu_srca & opb;
      4'b0101: alu_res = alu_srca | opb;
      4'b0110: alu_res = alu_srca ^ opb;
      4'b0111: alu_res = {alu_imm, 16'h0};
      4'b1010: alu_res = {31'h0, $signed(alu_srca) < $signed(opb)};
      4'b1011: alu_res = {31'h0, alu_srca < opb};
      default: alu_res = '0;
    endcase
    alu_zero = (alu_res == '0);
    alu_neg  = alu_res[31];
  end

  typedef struct packed {
    logic        wb_en;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        exc;
    logic [1:0]  cause;
    logic        fz;
    logic        fn;
  } exp_t;

  typedef struct packed {
    logic        done;
    int          lat;
    int          wb_cnt;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        exc;
    logic [1:0]  cause;
    logic [1:0]  cause4;
    logic        alu_u;
    logic        ready4;
    logic        fz;
    logic        fn;
  } obs_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic mz = 1'b0, mn = 1'b0;

  function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Architectural reference model of one instruction.
  function automatic exp_t model(input logic [31:0] ins);
    exp_t        e;
    logic [31:0] a, b, se, ze, res;
    logic        legal, ovf, trap;
    logic [5:0]  op, fn;
    op = ins[31:26]; fn = ins[5:0];
    a  = rf[ins[25:21]]; b = rf[ins[20:16]];
    se = {{16{ins[15]}}, ins[15:0]}; ze = {16'h0, ins[15:0]};
    legal = 1'b1; ovf = 1'b0; res = '0; e = '0;
    if (op == 6'h00) begin
      case (fn)
        6'h20: begin res = a + b; ovf = (a[31] == b[31]) && (res[31] != a[31]); end
        6'h21: res = a + b;
        6'h22: begin res = a - b; ovf = (a[31] != b[31]) && (res[31] != a[31]); end
        6'h23: res = a - b;
        6'h24: res = a & b;
        6'h25: res = a | b;
        6'h26: res = a ^ b;
        6'h2A: res = {31'h0, $signed(a) < $signed(b)};
        6'h2B: res = {31'h0, a < b};
        default: legal = 1'b0;
      endcase
      e.addr = ins[15:11];
    end else begin
      case (op)
        6'h08: begin res = a + se; ovf = (a[31] == se[31]) && (res[31] != a[31]); end
        6'h09: res = a + se;
        6'h0A: res = {31'h0, $signed(a) < $signed(se)};
        6'h0B: res = {31'h0, a < se};
        6'h0C: res = a & ze;
        6'h0D: res = a | ze;
        6'h0E: res = a ^ ze;
        6'h0F: res = {ins[15:0], 16'h0};
        default: legal = 1'b0;
      endcase
      e.addr = ins[20:16];
    end
`ifdef ALU_OVF_TRAP_EN
    trap = legal && ovf;
`else
    trap = ovf && 1'b0;
`endif
    e.exc   = !legal || trap;
    e.cause = !legal ? 2'b01 : (trap ? 2'b10 : 2'b00);
    e.wb_en = !e.exc && (e.addr != 5'd0);
    e.data  = res;
    e.fz    = e.exc ? mz : (res == 32'h0);
    e.fn    = e.exc ? mn : res[31];
    return e;
  endfunction

  task automatic push_exp(input logic [31:0] ins);
    exp_t e;
    e = model(ins);
    sb.push_back(e);
    mz = e.fz;
    mn = e.fn;
  endtask

  // Drives one instruction and records what the DUT does over the following cycles.
  task automatic run_one(input logic [31:0] ins, output obs_t o);
    int g;
    o = '0;
    @(negedge clk);
    g = 0;
    while (!instr_ready && g < 10) begin @(negedge clk); g++; end
    instr_valid = 1'b1;
    instr = ins;
    push_exp(ins);
    @(negedge clk);
    instr_valid = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (k == 2) o.alu_u = alu_u;
      if (wb_en) o.wb_cnt = o.wb_cnt + 1;
      if (done && !o.done) begin
        o.done = 1'b1; o.lat = k; o.addr = wb_addr; o.data = wb_data;
        o.exc = exc; o.cause = exc_cause;
      end
      if (k == 4) begin
        o.ready4 = instr_ready; o.fz = flag_z; o.fn = flag_n; o.cause4 = exc_cause;
      end
      if (k >= 4 && o.done) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    logic [7:0] got;
    rst_n = 1'b0; instr_valid = 1'b0; instr = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    got = {instr_ready, wb_en, done, exc, exc_cause, flag_z, flag_n};
    vectors++;
    if (got !== 8'b1000_0000) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b want 10000000 (ready,wb_en,done,exc,cause,z,n)", got);
    end
    vectors++;
    if ({wb_data, alu_srca, alu_srcb, alu_imm, alu_af} !== '0) begin
      miscompares++;
      $display("FAIL reset_data: wb_data %h srca %h srcb %h imm %h af %h want all 0",
               wb_data, alu_srca, alu_srcb, alu_imm, alu_af);
    end
  endtask

  task automatic test_add;
    obs_t o; exp_t e;
    rf[1] = 32'd5; rf[2] = 32'd7;
    run_one(r_ins(5'd1, 5'd2, 5'd3, 6'h20), o);
    e = sb.pop_front();
    vectors++;
    if (o.lat !== 3) begin
      miscompares++; $display("FAIL add_latency: got %0d want 3", o.lat);
    end
    vectors++;
    if (o.wb_cnt !== 1 || o.addr !== e.addr || o.data !== e.data) begin
      miscompares++;
      $display("FAIL add_wb: wb_cnt %0d addr %0d data %h want 1 %0d %h",
               o.wb_cnt, o.addr, o.data, e.addr, e.data);
    end
    vectors++;
    if (o.ready4 !== 1'b1 || o.exc !== 1'b0) begin
      miscompares++; $display("FAIL add_ready_exc: ready %b exc %b want 1 0", o.ready4, o.exc);
    end
  endtask

  task automatic test_imm;
    obs_t o; exp_t e;
    rf[0] = 32'h0;
    run_one(i_ins(6'h0D, 5'd0, 5'd4, 16'h8000), o);
    e = sb.pop_front();
    vectors++;
    if (o.alu_u !== 1'b1 || o.wb_cnt !== 1 || o.addr !== 5'd4 || o.data !== e.data) begin
      miscompares++;
      $display("FAIL ori: u %b wb_cnt %0d addr %0d data %h want 1 1 4 %h",
               o.alu_u, o.wb_cnt, o.addr, o.data, e.data);
    end
    run_one(i_ins(6'h08, 5'd0, 5'd5, 16'h8000), o);
    e = sb.pop_front();
    vectors++;
    if (o.alu_u !== 1'b0 || o.wb_cnt !== 1 || o.data !== e.data) begin
      miscompares++;
      $display("FAIL addi: u %b wb_cnt %0d data %h want 0 1 %h", o.alu_u, o.wb_cnt, o.data, e.data);
    end
    vectors++;
    if (o.fn !== e.fn || o.fz !== e.fz) begin
      miscompares++; $display("FAIL addi_flags: n %b z %b want %b %b", o.fn, o.fz, e.fn, e.fz);
    end
  endtask

  task automatic test_overflow;
    obs_t o; exp_t e;
    logic [31:0] prog [3];
    rf[6] = 32'h7FFF_FFFF; rf[7] = 32'h1; rf[10] = 32'h8000_0000;
    prog[0] = r_ins(5'd6, 5'd7, 5'd8, 6'h20);   // add: signed overflow
    prog[1] = r_ins(5'd6, 5'd7, 5'd9, 6'h21);   // addu: never traps
    prog[2] = r_ins(5'd10, 5'd7, 5'd11, 6'h22); // sub: signed overflow
    foreach (prog[i]) begin
      run_one(prog[i], o);
      e = sb.pop_front();
      vectors++;
      if (o.wb_cnt !== int'(e.wb_en) || o.exc !== e.exc || o.cause !== e.cause) begin
        miscompares++;
        $display("FAIL ovf_%0d: wb_cnt %0d exc %b cause %b want %0d %b %b",
                 i, o.wb_cnt, o.exc, o.cause, e.wb_en, e.exc, e.cause);
      end
      vectors++;
      if ((e.wb_en && o.data !== e.data) || o.fz !== e.fz || o.fn !== e.fn) begin
        miscompares++;
        $display("FAIL ovf_data_%0d: data %h z %b n %b want %h %b %b",
                 i, o.data, o.fz, o.fn, e.data, e.fz, e.fn);
      end
    end
  endtask

  task automatic test_illegal;
    obs_t o; exp_t e;
    logic [31:0] prog [2];
    prog[0] = i_ins(6'h3F, 5'd1, 5'd2, 16'h1234);
    prog[1] = r_ins(5'd1, 5'd2, 5'd3, 6'h00);
    foreach (prog[i]) begin
      run_one(prog[i], o);
      e = sb.pop_front();
      vectors++;
      if (!o.done || o.exc !== 1'b1 || o.cause !== 2'b01 || o.wb_cnt !== 0) begin
        miscompares++;
        $display("FAIL illegal_%0d: done %b exc %b cause %b wb_cnt %0d want 1 1 01 0",
                 i, o.done, o.exc, o.cause, o.wb_cnt);
      end
      vectors++;
      if (o.fz !== e.fz || o.fn !== e.fn || o.ready4 !== 1'b1 || o.cause4 !== 2'b01) begin
        miscompares++;
        $display("FAIL illegal_after_%0d: z %b n %b ready %b cause %b want %b %b 1 01",
                 i, o.fz, o.fn, o.ready4, o.cause4, e.fz, e.fn);
      end
    end
  endtask

  task automatic test_alu_table;
    obs_t o; exp_t e;
    logic [31:0] prog [13];
    rf[12] = 32'hF0F0_1234; rf[13] = 32'h0F0F_8001; rf[14] = 32'hFFFF_FFFE; rf[15] = 32'h3;
    prog[0]  = r_ins(5'd12, 5'd13, 5'd16, 6'h22);
    prog[1]  = r_ins(5'd13, 5'd12, 5'd17, 6'h23);
    prog[2]  = r_ins(5'd12, 5'd13, 5'd18, 6'h24);
    prog[3]  = r_ins(5'd12, 5'd13, 5'd19, 6'h25);
    prog[4]  = r_ins(5'd12, 5'd13, 5'd20, 6'h26);
    prog[5]  = r_ins(5'd14, 5'd15, 5'd21, 6'h2A);
    prog[6]  = r_ins(5'd14, 5'd15, 5'd22, 6'h2B);
    prog[7]  = i_ins(6'h0A, 5'd14, 5'd23, 16'hFFFF);
    prog[8]  = i_ins(6'h0B, 5'd15, 5'd24, 16'hFFFF);
    prog[9]  = i_ins(6'h0C, 5'd12, 5'd25, 16'hFF00);
    prog[10] = i_ins(6'h0E, 5'd13, 5'd26, 16'hFFFF);
    prog[11] = i_ins(6'h0F, 5'd0, 5'd27, 16'hABCD);
    prog[12] = i_ins(6'h09, 5'd14, 5'd28, 16'h0005);
    foreach (prog[i]) begin
      run_one(prog[i], o);
      e = sb.pop_front();
      vectors++;
      if (o.wb_cnt !== 1 || o.addr !== e.addr || o.data !== e.data || o.lat !== 3) begin
        miscompares++;
        $display("FAIL table_%0d: wb_cnt %0d addr %0d data %h lat %0d want 1 %0d %h 3",
                 i, o.wb_cnt, o.addr, o.data, o.lat, e.addr, e.data);
      end
    end
  endtask

  task automatic test_reset_mid;
    obs_t o; exp_t e;
    int bad;
    rf[1] = 32'd5; rf[2] = 32'd7;
    @(negedge clk);
    instr_valid = 1'b1; instr = r_ins(5'd1, 5'd2, 5'd3, 6'h20);
    push_exp(instr);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    bad = 0;
    repeat (3) begin @(negedge clk); if (wb_en || done) bad++; end
    rst_n = 1'b1;
    e = sb.pop_front();
    mz = 1'b0; mn = 1'b0;
    repeat (3) begin @(negedge clk); if (wb_en || done) bad++; end
    vectors++;
    if (bad !== 0 || instr_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid: stray wb/done %0d ready %b want 0 1", bad, instr_ready);
    end
    run_one(r_ins(5'd1, 5'd2, 5'd3, 6'h20), o);
    e = sb.pop_front();
    vectors++;
    if (o.wb_cnt !== 1 || o.data !== e.data || o.lat !== 3) begin
      miscompares++;
      $display("FAIL reset_mid_next: wb_cnt %0d data %h lat %0d want 1 %h 3",
               o.wb_cnt, o.data, o.lat, e.data);
    end
  endtask

  task automatic test_busy;
    exp_t e;
    logic [31:0] ins;
    int acc, second, wbc, dn;
    rf[1] = 32'd5; rf[2] = 32'd7;
    ins = r_ins(5'd1, 5'd2, 5'd0, 6'h20);
    @(negedge clk);
    instr = ins; instr_valid = 1'b1;
    acc = 0; second = -1; wbc = 0; dn = 0;
    for (int n = 0; n < 12; n++) begin
      if (instr_valid && instr_ready) begin
        acc++; push_exp(ins);
        if (acc == 2) second = n;
      end
      if (wb_en) wbc++;
      if (done) begin
        dn++;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          vectors++;
          if (wb_en !== e.wb_en) begin
            miscompares++; $display("FAIL r0_wb_en: got %b want %b", wb_en, e.wb_en);
          end
        end
      end
      @(negedge clk);
    end
    instr_valid = 1'b0;
    repeat (4) @(negedge clk);
    vectors++;
    if (acc !== 3 || second !== 4) begin
      miscompares++;
      $display("FAIL busy_accepts: count %0d second at %0d want 3 4", acc, second);
    end
    vectors++;
    if (wbc !== 0 || dn !== 3 || sb.size() !== 0) begin
      miscompares++;
      $display("FAIL busy_wb: wb_en %0d done %0d pending %0d want 0 3 0", wbc, dn, sb.size());
    end
  endtask

  initial begin
    foreach (rf[i]) rf[i] = 32'h0;
    test_reset();
    test_add();
    test_imm();
    test_overflow();
    test_illegal();
    test_alu_table();
    test_reset_mid();
    test_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 SHALL have parameter DW, default 32, datapath width.
REQ-002 SHALL have parameter AW, default 5, register-address width.
REQ-003 SHALL have ports: clk  in  1  single clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: instr_valid  in  1  instruction offered; instr  in  32  instruction word; instr_ready  out  1  accept strobe.
REQ-005 SHALL have ports: rf_raddr_a/rf_raddr_b  out  AW  rs/rt; rf_rdata_a/rf_rdata_b  in  DW  register-file data, valid one cycle after address.
REQ-006 SHALL have ports: alu_af  out  4  selector; alu_i  out  1  immediate select; alu_u  out  1  zero-extend; alu_imm  out  16; alu_srca/alu_srcb  out  DW.
REQ-007 SHALL have ports: alu_res  in  DW; alu_zero, alu_neg, alu_ovf  in  1  ALU flags.
REQ-008 SHALL have ports: wb_en  out  1; wb_addr  out  AW; wb_data  out  DW; done  out  1; exc  out  1; exc_cause  out  2 (01 illegal, 10 overflow); flag_z, flag_n  out  1  registered flags.

Function
REQ-009 SHALL implement FSM IDLE->READ->EXEC->WB->IDLE; instr_ready=1 only in IDLE.
REQ-010 SHALL capture instr and drive rf_raddr_a=instr[25:21], rf_raddr_b=instr[20:16] on instr_valid&&instr_ready; instr_valid ignored outside IDLE.
REQ-011 SHALL in READ capture rf_rdata_a/b and decode; R-type (opcode 0) funct 20/21/22/23/24/25/26/2A/2B hex -> af 0000/0001/0010/0011/0100/0101/0110/1010/1011, i=0.
REQ-012 SHALL decode I-type opcodes 08/09/0A/0B (hex) -> af 0000/0001/1010/1011 with u=0; 0C/0D/0E -> 0100/0101/0110 with u=1; 0F -> 0111; i=1, imm=instr[15:0].
REQ-013 SHALL flag any other opcode/funct as illegal and skip EXEC (READ->WB).
REQ-014 SHALL hold alu_* outputs stable from registered values throughout EXEC, and capture alu_res, alu_zero, alu_neg, alu_ovf at end of EXEC.
REQ-015 SHALL in WB pulse done for one cycle and pulse wb_en with wb_data=captured result, wb_addr=instr[15:11] (R) or instr[20:16] (I).
REQ-016 SHALL suppress wb_en when wb_addr==0, on illegal, or on trapped overflow (REQ-022).
REQ-017 SHALL pulse exc with exc_cause in WB on illegal or trapped overflow; exc_cause holds until next WB.
REQ-018 SHALL update flag_z/flag_n in WB only on a non-excepting instruction.
REQ-019 SHALL give latency: accept at cycle 0, wb_en/done at cycle 3; back-to-back accept earliest at cycle 4.

Reset
REQ-020 SHALL on rst_n low, at any state: state=IDLE, instr_ready=1 after release, wb_en/done/exc=0, all other outputs and internal registers 0; an in-flight instruction is discarded with no writeback.

Configuration
REQ-021 SHALL honour macro ALU_OVF_TRAP_EN.
REQ-022 SHALL with ALU_OVF_TRAP_EN defined, treat alu_ovf=1 on af 0000/0010 as exception cause 10 with writeback suppressed; without it, ignore alu_ovf, always write back, exc_cause never 10.

Structure
REQ-023 SHALL place opcode/funct constants, af encodings, FSM state enum and exc_cause codes in shared package alu_pkg.
REQ-024 SHALL isolate the combinational opcode/funct -> {af,i,u,illegal} map in sub-module alu_decode.

Verification
REQ-025 SHALL cover: add r3,r1,r2 with r1=5,r2=7 -> wb_en cycle 3, wb_addr=3, wb_data=12, done=1.
REQ-026 SHALL cover: ori r4,r0,0x8000 -> alu_u=1, wb_data=0x00008000; addi with imm 0x8000 -> alu_u=0, r1=0 gives 0xFFFF8000, flag_n=1.
REQ-027 SHALL cover: add 0x7FFFFFFF+1 -> with ALU_OVF_TRAP_EN exc=1, cause=10, no wb_en; without it wb_data=0x80000000.
REQ-028 SHALL cover: opcode 0x3F -> exc=1, cause=01, no wb_en, flags unchanged, back in IDLE cycle 4.
REQ-029 SHALL cover: rst_n asserted during EXEC -> no wb_en/done, instr_ready=1 after release, next instruction correct.
REQ-030 SHALL cover: write to r0 and instr_valid held high during busy -> wb_en=0 for r0; only one accept per 4 cycles.
